arm_regfile: RTL
================

Name: arm_regfile

Overview:
- Integer register file for the ARM core. It is the responder to the decode stage's three register-read ports (read_0/read_1/read_2 and rdata_0/rdata_1/rdata_2).
- Writeback commits results through a single write port.
- A per-register pending-write scoreboard gives decode hazard flags so it can stall on in-flight results.
- r15 is not stored. Decode substitutes the PC itself; writes to r15 are redirected to fetch as a PC load.

Parameters:
- NREGS, 16, architectural register count; index width is fixed at 4.
- CNT_W, 2, width of each pending-write counter; maximum in-flight writes per register is 2^CNT_W - 1.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_b  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- read_0  input  4  read port 0 register index (Rn).
- read_1  input  4  read port 1 register index (Rm).
- read_2  input  4  read port 2 register index (Rs).
- rdata_0  output  32  port 0 read data, combinational.
- rdata_1  output  32  port 1 read data, combinational.
- rdata_2  output  32  port 2 read data, combinational.
- hazard_0  output  1  port 0 register still has a pending write after this cycle.
- hazard_1  output  1  same, for port 1.
- hazard_2  output  1  same, for port 2.
- lock_req  input  1  issue claims a future write to lock_reg.
- lock_reg  input  4  register being claimed.
- lock_ack  output  1  claim accepted this cycle, combinational.
- write_req  input  1  writeback commit strobe.
- write_reg  input  4  destination index.
- write_data  input  32  result value.
- pc_load  output  1  registered strobe: r15 was written last cycle.
- pc_value  output  32  registered new PC value; valid while pc_load is high.
- sb_error  output  1  sticky flag: a write arrived for a register whose pending count was zero.

Behaviour:
- Reset (rst_b == 0 at a clock edge):
  - r0..r14 clear to 0.
  - All pending counts clear to 0.
  - pc_load, pc_value and sb_error clear to 0.
  - Reset overrides any lock or write presented in the same cycle; that lock or write is lost.
- Read ports, zero latency:
  - rdata_n = regs[read_n].
  - Write-through bypass: if write_req is high and write_reg == read_n and read_n != 15, rdata_n = write_data.
  - read_n == 15 returns 32'h0; decode supplies the PC for this case.
- Write port:
  - When write_req is high and write_reg != 15, regs[write_reg] <= write_data at the edge.
  - When write_req is high and write_reg == 15, the next cycle drives pc_load = 1 and pc_value = write_data. No register is updated.
  - pc_load is a single-cycle pulse.
- Scoreboard, one counter cnt[r] of CNT_W bits per register (r15 included):
  - lock_ack = lock_req && (cnt[lock_reg] != max || dec), where dec = write_req && write_reg == lock_reg && cnt[lock_reg] != 0.
  - At a saturated count, lock_ack stays low and issue must stall and retry.
  - Per register r, with inc = lock_ack && lock_reg == r and dec = write_req && write_reg == r && cnt[r] != 0:
    - inc and dec both set: count unchanged.
    - inc only: +1.
    - dec only: -1.
  - The count never wraps in either direction.
  - A write with cnt == 0 still updates the register and sets sb_error, which holds until reset. The count stays at 0.
- Hazards:
  - hazard_n = (cnt[read_n] - dec(read_n)) != 0, i.e. a write committing this cycle through the bypass clears the hazard if it was the last one pending.
  - A lock in the same cycle does not raise a hazard for that cycle's reads.
- Multiple ports reading the same index all see identical data and hazard.

Decomposition:
- Shared constants header: REG_PC = 4'hF, NREGS, CNT_W default.
- One natural sub-module: arm_scoreboard, which holds the counters, lock_ack, the hazard_n flags and sb_error.
- arm_regfile owns the storage, the bypass and the pc_load path.

Test Plan:
- Reset then read: hold rst_b = 0 for 2 cycles; read_0/1/2 = 1, 7, 14 -> rdata all 0, hazards 0, sb_error 0, pc_load 0.
- Write then read: lock r3 (lock_ack = 1, hazard on r3 next cycle); then write r3 = 32'hDEADBEEF with read_1 = 3 -> same cycle rdata_1 = DEADBEEF (bypass) and hazard_1 = 0; next cycle rdata_1 still DEADBEEF from storage.
- Saturation: lock r5 three times -> ack 1, 1, 1; 4th lock -> lock_ack = 0. A 4th lock issued together with write r5 -> ack 1 and count stays 3.
- r15: write r15 = 32'h00008000 -> next cycle pc_load = 1 and pc_value = 00008000; the cycle after, pc_load = 0; read_0 = 15 returns 0.
- Error: write r9 with no prior lock -> r9 updated, sb_error = 1 and still 1 after 10 idle cycles; cleared only by rst_b = 0.
- Reset mid-operation: lock r2 and r4, then assert rst_b = 0 in the same cycle as write r2 = 5 -> after reset r2 = 0, all hazards 0, and a subsequent lock of r2 is acked.

Source files
------------

// File: rtl/arm_regfile_pkg.sv
// Shared constants for the ARM integer register file and its pending-write scoreboard.
package arm_regfile_pkg;

  localparam int unsigned REG_IDX_W = 4;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NREGS_DEF = 16;
  localparam int unsigned CNT_W_DEF = 2;

  localparam logic [REG_IDX_W-1:0] REG_PC = 4'hF;

endpackage

// File: rtl/arm_scoreboard.sv
// Per-register pending-write counters: grants issue claims, flags read hazards,
// and latches an error when a commit arrives with nothing pending.
module arm_scoreboard
  import arm_regfile_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [REG_IDX_W-1:0] read_0,
  input  logic [REG_IDX_W-1:0] read_1,
  input  logic [REG_IDX_W-1:0] read_2,
  input  logic                 lock_req,
  input  logic [REG_IDX_W-1:0] lock_reg,
  input  logic                 write_req,
  input  logic [REG_IDX_W-1:0] write_reg,
  output logic                 lock_ack,
  output logic                 hazard_0,
  output logic                 hazard_1,
  output logic                 hazard_2,
  output logic                 sb_error
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt [NREGS];
  logic             r_sb_error;
  logic [NREGS-1:0] w_inc;
  logic [NREGS-1:0] w_dec;

  // A commit only retires a claim when one is outstanding, so the count never underflows.
  always_comb begin
    w_inc    = '0;
    w_dec    = '0;
    for (int r = 0; r < NREGS; r++) begin
      w_dec[r] = write_req && (write_reg == REG_IDX_W'(r)) && (r_cnt[r] != '0);
    end
    lock_ack = lock_req && ((r_cnt[lock_reg] != CNT_MAX) || w_dec[lock_reg]);
    for (int r = 0; r < NREGS; r++) begin
      w_inc[r] = lock_ack && (lock_reg == REG_IDX_W'(r));
    end
  end

  // Hazard reflects the count after this cycle's commit; same-cycle claims are not visible.
  assign hazard_0 = (r_cnt[read_0] - CNT_W'(w_dec[read_0])) != '0;
  assign hazard_1 = (r_cnt[read_1] - CNT_W'(w_dec[read_1])) != '0;
  assign hazard_2 = (r_cnt[read_2] - CNT_W'(w_dec[read_2])) != '0;
  assign sb_error = r_sb_error;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      for (int r = 0; r < NREGS; r++) begin
        r_cnt[r] <= '0;
      end
      r_sb_error <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        case ({w_inc[r], w_dec[r]})
          2'b10:   r_cnt[r] <= r_cnt[r] + CNT_W'(1);
          2'b01:   r_cnt[r] <= r_cnt[r] - CNT_W'(1);
          default: r_cnt[r] <= r_cnt[r];
        endcase
      end
      if (write_req && (r_cnt[write_reg] == '0)) begin
        r_sb_error <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/arm_regfile.sv
// ARM integer register file: three bypassed read ports, one write port,
// r15 writes redirected to fetch as a registered PC load.
module arm_regfile
  import arm_regfile_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [REG_IDX_W-1:0] read_0,
  input  logic [REG_IDX_W-1:0] read_1,
  input  logic [REG_IDX_W-1:0] read_2,
  output logic [DATA_W-1:0]    rdata_0,
  output logic [DATA_W-1:0]    rdata_1,
  output logic [DATA_W-1:0]    rdata_2,
  output logic                 hazard_0,
  output logic                 hazard_1,
  output logic                 hazard_2,
  input  logic                 lock_req,
  input  logic [REG_IDX_W-1:0] lock_reg,
  output logic                 lock_ack,
  input  logic                 write_req,
  input  logic [REG_IDX_W-1:0] write_reg,
  input  logic [DATA_W-1:0]    write_data,
  output logic                 pc_load,
  output logic [DATA_W-1:0]    pc_value,
  output logic                 sb_error
);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              r_pc_load;
  logic [DATA_W-1:0] r_pc_value;
  logic              w_pc_write;

  assign w_pc_write = write_req && (write_reg == REG_PC);

  // r15 reads return zero (decode substitutes the PC); others bypass a same-cycle commit.
  assign rdata_0 = (read_0 == REG_PC) ? '0 :
                   (write_req && (write_reg == read_0)) ? write_data : r_regs[read_0];
  assign rdata_1 = (read_1 == REG_PC) ? '0 :
                   (write_req && (write_reg == read_1)) ? write_data : r_regs[read_1];
  assign rdata_2 = (read_2 == REG_PC) ? '0 :
                   (write_req && (write_reg == read_2)) ? write_data : r_regs[read_2];

  assign pc_load  = r_pc_load;
  assign pc_value = r_pc_value;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      for (int r = 0; r < NREGS; r++) begin
        r_regs[r] <= '0;
      end
      r_pc_load  <= 1'b0;
      r_pc_value <= '0;
    end else begin
      if (write_req && !w_pc_write) begin
        r_regs[write_reg] <= write_data;
      end
      r_pc_load <= w_pc_write;
      if (w_pc_write) begin
        r_pc_value <= write_data;
      end
    end
  end

  arm_scoreboard #(
    .NREGS (NREGS),
    .CNT_W (CNT_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst_b     (rst_b),
    .read_0    (read_0),
    .read_1    (read_1),
    .read_2    (read_2),
    .lock_req  (lock_req),
    .lock_reg  (lock_reg),
    .write_req (write_req),
    .write_reg (write_reg),
    .lock_ack  (lock_ack),
    .hazard_0  (hazard_0),
    .hazard_1  (hazard_1),
    .hazard_2  (hazard_2),
    .sb_error  (sb_error)
  );

endmodule
